pc_sequencer: RTL

Program-counter register and next-PC selector for the single-cycle CPU. Holds the current fetch address and drives it to the instruction memory and to the PC incrementer. Consumes the incrementer's PC+4 result plus the branch, jump and register targets, and loads the selected next PC on each enabled clock edge. Also owns a small run/halt/fault state machine and a retired-instruction counter.

---
 rtl/pc_sequencer.sv | 58 +++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter register, next-PC selector, run/halt/fault FSM and retired counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic        Halt,
  input  logic [31:0] pcPlus4,
  input  logic [31:0] immExt,
  input  logic [25:0] jumpAddr,
  input  logic [31:0] rsData,
  output logic [31:0] curPC,
  output logic [31:0] nextPC,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);
  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ret_q, ret_d;
  logic        commit, misaligned;
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
    end
  end
  always_comb begin
    nextPC = PCSrc == 2'b00 ? pcPlus4 :
             PCSrc == 2'b01 ? pcPlus4 + (immExt << 2) :
             PCSrc == 2'b10 ? rsData :
                              {pcPlus4[31:28], jumpAddr, 2'b00};
    misaligned = |nextPC[1:0];
    commit = PCWre && state_q == RUN;
    state_d = state_q;
    pc_d = pc_q;
    ret_d = ret_q;
    // Halt outranks a misaligned target; a faulting instruction does not retire.
    if (commit) begin
      state_d = Halt ? HALTED : misaligned ? FAULT : RUN;
      pc_d = (Halt || misaligned) ? pc_q : nextPC;
      ret_d = (!Halt && misaligned) ? ret_q : ret_q + 32'd1;
    end
  end
  always_comb begin
    curPC = pc_q;
    retired = ret_q;
    halted = state_q == HALTED;
    fault = state_q == FAULT;
  end
endmodule
